// File: rtl/mc_core_pkg.sv
// Shared constants and types for the multi-cycle core: opcodes, functs,
// FSM state encoding, ALU operation codes and immediate sign extension.
package mc_core_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam int SEXT_W = 64;

   typedef enum logic [4:0] {
      ST_FETCH  = 5'b00001,
      ST_DECODE = 5'b00010,
      ST_EXEC   = 5'b00100,
      ST_WB     = 5'b01000,
      ST_HALT   = 5'b10000
   } mc_state_t;

   typedef enum logic [2:0] {
      ALU_NOP,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   // Wide result; callers cast down to their own datapath or PC width.
   function automatic logic [SEXT_W-1:0] sext16(input logic [15:0] imm);
      return {{(SEXT_W-16){imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// entry 0 hard-wired to zero, asynchronous clear of every entry.
module mc_regfile #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   localparam int RA_W  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [RA_W-1:0]   i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [RA_W-1:0]   i_raddr_a,
   output logic [DATA_W-1:0] o_rdata_a,
   input  logic [RA_W-1:0]   i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_b
);

   logic [DATA_W-1:0] r_regs [NREG];

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         // Entry 0 never matches the write condition, so it stays at its reset value.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_regs[gi] <= '0;
            end else if (i_we && (i_waddr == RA_W'(gi)) && (gi != 0)) begin
               r_regs[gi] <= i_wdata;
            end
         end
      end
   endgenerate

   assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mc_core.sv
// Multi-cycle core: FETCH/DECODE/EXEC/WB/HALT sequencer, IR, PC and ALU.
// Define MC_CORE_BRANCH_EN to decode beq; otherwise op 0x04 is illegal.
module mc_core
   import mc_core_pkg::*;
#(
   parameter int              DATA_W   = 32,
   parameter int              NREG     = 32,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   localparam int             RA_W     = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_data,
   output logic [PC_W-1:0]   PC_Out,
   output logic [31:0]       Inst_Out,
   output logic              wb_we,
   output logic [RA_W-1:0]   wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              ALU_Flag,
   output logic              halted,
   output logic              illegal
);

   mc_state_t         r_state;
   mc_state_t         w_state_next;
   logic [PC_W-1:0]   r_pc;
   logic [31:0]       r_ir;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_alu;
   logic              r_zero;
   logic              r_illegal;

   logic [5:0]        w_op;
   logic [5:0]        w_funct;
   logic [15:0]       w_imm;
   logic [RA_W-1:0]   w_rs;
   logic [RA_W-1:0]   w_rt;
   logic [RA_W-1:0]   w_rd;
   logic [RA_W-1:0]   w_dest;
   alu_op_t           w_alu_op;
   logic              w_use_imm;
   logic              w_is_wb;
   logic              w_is_halt;
   logic              w_is_ill;
   logic [DATA_W-1:0] w_opb;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_alu_zero;
   logic [DATA_W-1:0] w_rf_a;
   logic [DATA_W-1:0] w_rf_b;
   logic [PC_W-1:0]   w_pc_inc;
   logic [PC_W-1:0]   w_pc_next;
`ifdef MC_CORE_BRANCH_EN
   logic              w_is_beq;
`endif

   assign w_op    = r_ir[31:26];
   assign w_rs    = r_ir[21 +: RA_W];
   assign w_rt    = r_ir[16 +: RA_W];
   assign w_rd    = r_ir[11 +: RA_W];
   assign w_funct = r_ir[5:0];
   assign w_imm   = r_ir[15:0];

   always_comb begin
      w_alu_op  = ALU_NOP;
      w_use_imm = 1'b0;
      w_is_wb   = 1'b0;
      w_is_halt = 1'b0;
      w_is_ill  = 1'b0;
      w_dest    = w_rd;
`ifdef MC_CORE_BRANCH_EN
      w_is_beq  = 1'b0;
`endif
      case (w_op)
         OP_RTYPE: begin
            w_is_wb = 1'b1;
            case (w_funct)
               FN_ADD:  w_alu_op = ALU_ADD;
               FN_SUB:  w_alu_op = ALU_SUB;
               FN_AND:  w_alu_op = ALU_AND;
               FN_OR:   w_alu_op = ALU_OR;
               FN_SLT:  w_alu_op = ALU_SLT;
               default: w_is_wb  = 1'b0;
            endcase
         end
         OP_ADDI: begin
            w_alu_op  = ALU_ADD;
            w_use_imm = 1'b1;
            w_is_wb   = 1'b1;
            w_dest    = w_rt;
         end
`ifdef MC_CORE_BRANCH_EN
         OP_BEQ: begin
            w_alu_op = ALU_SUB;
            w_is_beq = 1'b1;
         end
`endif
         OP_HALT: w_is_halt = 1'b1;
         default: w_is_ill  = 1'b1;
      endcase
   end

   assign w_opb = w_use_imm ? DATA_W'(sext16(w_imm)) : r_b;

   always_comb begin
      w_alu_res = '0;
      case (w_alu_op)
         ALU_ADD: w_alu_res = r_a + w_opb;
         ALU_SUB: w_alu_res = r_a - w_opb;
         ALU_AND: w_alu_res = r_a & w_opb;
         ALU_OR:  w_alu_res = r_a | w_opb;
         ALU_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_opb))};
         default: w_alu_res = '0;
      endcase
   end

   assign w_alu_zero = (w_alu_res == '0);
   assign w_pc_inc   = r_pc + PC_W'(1);

`ifdef MC_CORE_BRANCH_EN
   assign w_pc_next = (w_is_beq && (r_a == r_b)) ? (w_pc_inc + PC_W'(sext16(w_imm))) : w_pc_inc;
`else
   assign w_pc_next = w_pc_inc;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_FETCH:  if (imem_ack) w_state_next = ST_DECODE;
         ST_DECODE: w_state_next = ST_EXEC;
         ST_EXEC: begin
            if (w_is_halt) begin
               w_state_next = ST_HALT;
            end else if (w_is_wb) begin
               w_state_next = ST_WB;
            end else begin
               w_state_next = ST_FETCH;
            end
         end
         ST_WB:     w_state_next = ST_FETCH;
         ST_HALT:   w_state_next = ST_HALT;
         default:   w_state_next = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_alu     <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (imem_ack) r_ir <= imem_data;
            end
            ST_DECODE: begin
               r_a <= w_rf_a;
               r_b <= w_rf_b;
            end
            ST_EXEC: begin
               r_alu  <= w_alu_res;
               r_zero <= w_alu_zero;
               if (!w_is_wb && !w_is_halt) r_pc <= w_pc_next;
               if (w_is_ill) r_illegal <= 1'b1;
            end
            ST_WB:   r_pc <= w_pc_inc;
            default: ;
         endcase
      end
   end

   mc_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_we      (wb_we),
      .i_waddr   (w_dest),
      .i_wdata   (r_alu),
      .i_raddr_a (w_rs),
      .o_rdata_a (w_rf_a),
      .i_raddr_b (w_rt),
      .o_rdata_b (w_rf_b)
   );

   // Gated by rst so the request drops the moment reset asserts, not at the next edge.
   assign imem_req  = (r_state == ST_FETCH) && !rst;
   assign imem_addr = r_pc;
   assign PC_Out    = r_pc;
   assign Inst_Out  = r_ir;
   assign wb_we     = (r_state == ST_WB) && (w_dest != '0);
   assign wb_addr   = wb_we ? w_dest : '0;
   assign wb_data   = wb_we ? r_alu : '0;
   assign ALU_Flag  = r_zero;
   assign halted    = (r_state == ST_HALT);
   assign illegal   = r_illegal;

endmodule

// File: doc/mc_core.md
# mc_core

Parametrised multi-cycle successor to the single-cycle datapath. It fetches one 32-bit instruction over a req/ack handshake from an external instruction memory, then sequences decode, execute and writeback through an explicit state machine. Internally it holds a register file and an ALU. It sits between the instruction-memory wrapper and the top level, and its debug outputs drive the testbench monitors.

## Interface
- `DATA_W`, 32: datapath and register width.
- `NREG`, 32: register count, power of two; `RA_W = $clog2(NREG)`, at most 5.
- `PC_W`, 32: program-counter width; PC is a word address.
- `RESET_PC`, 0: PC value after reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_W: fetch address, equal to PC.
- `imem_ack` in 1: `imem_data` valid this cycle.
- `imem_data` in 32: instruction word.
- `PC_Out` out PC_W: current PC.
- `Inst_Out` out 32: latched instruction register (IR).
- `wb_we` out 1: one-cycle register-write strobe.
- `wb_addr` out RA_W: write address.
- `wb_data` out DATA_W: write data.
- `ALU_Flag` out 1: zero flag of the last EXEC.
- `halted` out 1: core stopped.
- `illegal` out 1: sticky unknown-opcode flag.

## Operation
- **Instruction fields:**
  - op [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
  - Only the low RA_W bits of each register field are used.
- **R-type, op 0x00, result to rd:**
  - funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - Any other funct executes as a NOP.
- **addi, op 0x08:** rt = rs + sign-extended imm.
- **beq, op 0x04:** taken when rs == rt.
- **halt, op 0x3F:** stops the core.
- **Unknown op:** NOP; sets `illegal`, which stays set until reset.
- **Arithmetic:** wraps modulo 2^DATA_W, with no overflow trap. slt returns 0 or 1.
- **Register 0:** always reads 0. Writes to it are suppressed, including `wb_we`.
- **State machine, one-hot, states FETCH, DECODE, EXEC, WB, HALT:**
  - FETCH: `imem_req`=1. On `imem_ack`=1, IR <= `imem_data` and go to DECODE; otherwise stay.
  - DECODE: latch A=reg[rs] and B=reg[rt], then go to EXEC.
  - EXEC: ALU result and zero flag are latched.
    - R-type and addi go to WB.
    - beq, NOP and illegal: PC <= next PC, go to FETCH.
    - halt goes to HALT.
  - WB: write the register, pulse `wb_we`, PC <= PC+1, go to FETCH.
  - HALT: stays there until reset.
- **PC update:** PC+1 normally; PC+1+sext(imm) when a beq is taken. Both wrap modulo 2^PC_W.

## Timing
- **Reset values:**
  - PC = RESET_PC; state FETCH; IR = 0; all registers 0.
  - `imem_req` = 1 from the first cycle after reset release.
  - `wb_we`, `wb_addr`, `wb_data`, `ALU_Flag`, `halted`, `illegal` all 0.
- **Reset asserted mid-operation:** all of the above take effect immediately and asynchronously. `imem_req` drops in the same cycle and an in-flight fetch is abandoned.
- **Handshake:**
  - `imem_req` and `imem_addr` are registered and held stable until an ack is sampled.
  - An ack while not in FETCH is ignored.
- **Cycles per instruction, with zero-wait ack (ack in the first FETCH cycle):**
  - ALU ops: 4 (FETCH, DECODE, EXEC, WB).
  - beq, NOP, illegal: 3.
  - Each wait cycle on `imem_ack` adds 1.
- **Writeback visibility:** `wb_*` are valid during the single cycle `wb_we`=1. The written value is readable by the next instruction's DECODE.
- **Halt:** `halted` rises the cycle after EXEC of a halt. From then on `imem_req` stays 0.

## Configuration
- **`MC_CORE_BRANCH_EN` defined:** beq decoded as specified above.
- **Not defined:**
  - op 0x04 is an unknown opcode: NOP, sets `illegal`.
  - The branch adder and comparator are removed.

## Structure
- **Package `mc_core_pkg`:**
  - Opcode and funct constants.
  - State enum `mc_state_t`.
  - ALU-op enum `alu_op_t`.
  - Sign-extension function.
- **Sub-module `mc_regfile`:** parametrised by DATA_W and NREG; two asynchronous read ports, one synchronous write port, r0 forced to zero, async reset clears all entries.
- **`mc_core` itself:** FSM, IR, PC and ALU.

## Test plan
- **Dependent ALU ops, zero-wait ack:**
  - Program: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2.
  - Required: r3 = 2. `wb_we` pulses at cycles 4, 8 and 12 after reset release. `ALU_Flag`=0.
- **Wait states:** ack delayed 3 cycles on every fetch -> each ALU instruction takes 7 cycles. `imem_addr` stays stable while waiting; PC sequence is 0, 1, 2.
- **Wrap, slt and r0:**
  - sub r4,r0,r1 with r1=5 -> r4 = 0xFFFFFFFB.
  - slt r5,r4,r1 -> 1.
  - add r0,r1,r1 -> `wb_we` stays 0 and r0 still reads 0.
- **Branch, macro defined:**
  - beq r1,r1,+2 at PC 10 -> next fetch address 13, `ALU_Flag`=1.
  - Macro undefined -> next fetch address 11 and `illegal`=1.
- **Halt and illegal:**
  - op 0x3F -> `halted`=1 and `imem_req`=0 for at least 20 cycles.
  - op 0x11 -> `illegal`=1 and execution continues at PC+1.
- **Reset mid-fetch:** assert `rst` while `imem_req`=1 and ack pending -> `imem_req` and outputs drop the same cycle. After release the fetch restarts at RESET_PC and the registers read 0.
